// File: rtl/regfile_write_sched.sv
// regfile_write_sched: sole owner of the GPR file write bus, shared by the rs/rt RAM copies.
// Arbitrates between the writeback stage and late load data. Late loads park in a
// one-entry pending buffer. Writes to r0 are accepted but never reach the RAMs.
// Optional macro RF_INIT_SWEEP_EN: after reset, zero every entry with a 2**WIDTHAD-cycle
// sweep before normal operation starts.
module regfile_write_sched #(
  parameter int WIDTH   = 32,
  parameter int WIDTHAD = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wb_valid,
  input  logic [WIDTHAD-1:0] wb_addr,
  input  logic [WIDTH-1:0]   wb_data,
  output logic               wb_stall,
  input  logic               ld_valid,
  input  logic [WIDTHAD-1:0] ld_addr,
  input  logic [WIDTH-1:0]   ld_data,
  output logic               ld_ready,
  output logic               rf_wren,
  output logic [WIDTHAD-1:0] rf_waddr,
  output logic [WIDTH-1:0]   rf_wdata,
  output logic               init_busy
);

  // Pending late-load buffer (single entry).
  logic               pend_v_q, pend_v_d;
  logic [WIDTHAD-1:0] pend_addr_q, pend_addr_d;
  logic [WIDTH-1:0]   pend_data_q, pend_data_d;

  // r0 writes are swallowed, so only nonzero destinations count as real writes.
  logic wb_w, ld_w;
  assign wb_w = wb_valid && (wb_addr != '0);
  assign ld_w = ld_valid && (ld_addr != '0);

`ifdef RF_INIT_SWEEP_EN
  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t             state_q, state_d;
  logic [WIDTHAD-1:0] cnt_q, cnt_d;

  // Sweep state and address counter; reset always restarts the sweep at entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Step through every entry once, then hand over to normal arbitration.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_INIT) begin
      cnt_d = cnt_q + {{(WIDTHAD-1){1'b0}}, 1'b1};
      if (cnt_q == {WIDTHAD{1'b1}}) state_d = S_RUN;
    end
  end

  assign init_busy = (state_q == S_INIT);
`else
  assign init_busy = 1'b0;
`endif

  // Pending buffer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else begin
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
    end
  end

  // Write-port arbitration: pending load first, then WB, then a fresh load.
  always_comb begin
    rf_wren     = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    wb_stall    = 1'b1;
    ld_ready    = 1'b0;
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    if (!rst_n) begin
      pend_v_d = 1'b0;
    end
`ifdef RF_INIT_SWEEP_EN
    else if (state_q == S_INIT) begin
      rf_wren  = 1'b1;
      rf_waddr = cnt_q;
      pend_v_d = 1'b0;
    end
`endif
    else begin
      wb_stall = 1'b0;
      if (pend_v_q) begin
        pend_v_d = 1'b0;
        if (wb_w && (wb_addr == pend_addr_q)) begin
          // WB is younger than the parked load: its data wins, load is cancelled.
          rf_wren  = 1'b1;
          rf_waddr = wb_addr;
          rf_wdata = wb_data;
        end else begin
          rf_wren  = 1'b1;
          rf_waddr = pend_addr_q;
          rf_wdata = pend_data_q;
          wb_stall = wb_w;
        end
      end else begin
        ld_ready = 1'b1;
        if (wb_w) begin
          rf_wren  = 1'b1;
          rf_waddr = wb_addr;
          rf_wdata = wb_data;
          // Same destination: the load is older and simply dropped.
          if (ld_w && (ld_addr != wb_addr)) begin
            pend_v_d    = 1'b1;
            pend_addr_d = ld_addr;
            pend_data_d = ld_data;
          end
        end else if (ld_w) begin
          rf_wren  = 1'b1;
          rf_waddr = ld_addr;
          rf_wdata = ld_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_sched.sv
// Bench for regfile_write_sched: directed scenarios plus randomized traffic checked
// against an architectural register-file model (program-order application of accepted writes).
module tb_regfile_write_sched;
  localparam int W = 32, AW = 5, DEPTH = 32;

  logic          clk = 0, rst_n = 0;
  logic          wb_valid = 0, ld_valid = 0;
  logic [AW-1:0] wb_addr = '0, ld_addr = '0;
  logic [W-1:0]  wb_data = '0, ld_data = '0;
  logic          wb_stall, ld_ready, rf_wren, init_busy;
  logic [AW-1:0] rf_waddr;
  logic [W-1:0]  rf_wdata;

  regfile_write_sched #(.WIDTH(W), .WIDTHAD(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .rf_wren(rf_wren), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [W-1:0] arch [DEPTH];
  logic [W-1:0] obs  [DEPTH];
  logic          s_wren, s_stall, s_ready, s_busy;
  logic [AW-1:0] s_addr;
  logic [W-1:0]  s_data;

`ifdef RF_INIT_SWEEP_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  function automatic logic [39:0] got_v();
    return {s_wren, s_addr, s_data, s_stall, s_ready};
  endfunction

  function automatic logic [39:0] exp_v(logic we, logic [AW-1:0] a, logic [W-1:0] d, logic st, logic rd);
    return {we, a, d, st, rd};
  endfunction

  task automatic sample();
    @(negedge clk);
    s_wren = rf_wren; s_addr = rf_waddr; s_data = rf_wdata;
    s_stall = wb_stall; s_ready = ld_ready; s_busy = init_busy;
  endtask

  // Commit the cycle: DUT write bus into obs, accepted requests into the arch model.
  task automatic tick();
    @(posedge clk);
    if (s_wren) obs[s_addr] = s_data;
    if (ld_valid && s_ready && ld_addr != 0) arch[ld_addr] = ld_data;
    if (wb_valid && !s_stall && wb_addr != 0) arch[wb_addr] = wb_data;
    #1;
  endtask

  task automatic idle();
    wb_valid = 0; ld_valid = 0;
  endtask

  task automatic set_wb(logic [AW-1:0] a, logic [W-1:0] d);
    wb_valid = 1; wb_addr = a; wb_data = d;
  endtask

  task automatic set_ld(logic [AW-1:0] a, logic [W-1:0] d);
    ld_valid = 1; ld_addr = a; ld_data = d;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) begin arch[i] = '0; obs[i] = '0; end
  endtask

  // Reset pulse and (if present) run through the clear sweep without checking.
  task automatic do_reset();
    idle();
    rst_n = 0;
    sample(); tick();
    rst_n = 1;
    clear_model();
    if (SWEEP) for (int i = 0; i < DEPTH; i++) begin sample(); tick(); end
  endtask

  // Park a load at r9 behind a WB write to r7.
  task automatic make_pend();
    set_wb(7, 32'h1234); set_ld(9, 32'hABCD);
    sample(); tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    sample();
    total++;
    if (got_v() !== exp_v(0, 0, 0, 1, 0) || s_busy !== SWEEP) begin
      bad++; $display("FAIL reset_outputs got=%h busy=%b exp=%h busy=%b", got_v(), s_busy, exp_v(0, 0, 0, 1, 0), SWEEP);
    end
    tick();
    rst_n = 1;
    clear_model();
    if (SWEEP) begin
      for (int i = 0; i < DEPTH; i++) begin
        sample();
        total++;
        if (got_v() !== exp_v(1, AW'(i), 0, 1, 0) || s_busy !== 1'b1) begin
          bad++; $display("FAIL sweep_%0d got=%h busy=%b exp=%h busy=1", i, got_v(), s_busy, exp_v(1, AW'(i), 0, 1, 0));
        end
        tick();
      end
    end
    sample();
    total++;
    if (got_v() !== exp_v(0, 0, 0, 0, 1) || s_busy !== 1'b0) begin
      bad++; $display("FAIL run_entry got=%h busy=%b exp=%h busy=0", got_v(), s_busy, exp_v(0, 0, 0, 0, 1));
    end
    tick();
  endtask

  task automatic test_wb_and_load();
    set_wb(7, 32'h1234); set_ld(9, 32'hABCD);
    sample();
    total++;
    if (got_v() !== exp_v(1, 7, 32'h1234, 0, 1)) begin
      bad++; $display("FAIL wbld_first got=%h exp=%h", got_v(), exp_v(1, 7, 32'h1234, 0, 1));
    end
    tick(); idle(); sample();
    total++;
    if (got_v() !== exp_v(1, 9, 32'hABCD, 0, 0)) begin
      bad++; $display("FAIL wbld_pend_drain got=%h exp=%h", got_v(), exp_v(1, 9, 32'hABCD, 0, 0));
    end
    tick(); sample();
    total++;
    if (got_v() !== exp_v(0, 0, 0, 0, 1)) begin
      bad++; $display("FAIL wbld_after got=%h exp=%h", got_v(), exp_v(0, 0, 0, 0, 1));
    end
    tick();
  endtask

  task automatic test_stall();
    make_pend();
    set_wb(4, 32'h55);
    sample();
    total++;
    if (got_v() !== exp_v(1, 9, 32'hABCD, 1, 0)) begin
      bad++; $display("FAIL stall_pend_first got=%h exp=%h", got_v(), exp_v(1, 9, 32'hABCD, 1, 0));
    end
    tick(); sample();
    total++;
    if (got_v() !== exp_v(1, 4, 32'h55, 0, 1)) begin
      bad++; $display("FAIL stall_wb_retry got=%h exp=%h", got_v(), exp_v(1, 4, 32'h55, 0, 1));
    end
    tick(); idle();
    make_pend();
    set_wb(0, 32'hFFFF);
    sample();
    total++;
    if (got_v() !== exp_v(1, 9, 32'hABCD, 0, 0)) begin
      bad++; $display("FAIL stall_r0_nostall got=%h exp=%h", got_v(), exp_v(1, 9, 32'hABCD, 0, 0));
    end
    tick(); idle(); sample(); tick();
  endtask

  task automatic test_cancel();
    make_pend();
    set_wb(9, 32'h77);
    sample();
    total++;
    if (got_v() !== exp_v(1, 9, 32'h77, 0, 0)) begin
      bad++; $display("FAIL cancel_wb_wins got=%h exp=%h", got_v(), exp_v(1, 9, 32'h77, 0, 0));
    end
    tick(); idle(); sample();
    total++;
    if (got_v() !== exp_v(0, 0, 0, 0, 1)) begin
      bad++; $display("FAIL cancel_no_late_write got=%h exp=%h", got_v(), exp_v(0, 0, 0, 0, 1));
    end
    tick();
  endtask

  task automatic test_same_addr_drop();
    set_wb(3, 32'h11); set_ld(3, 32'h22);
    sample();
    total++;
    if (got_v() !== exp_v(1, 3, 32'h11, 0, 1)) begin
      bad++; $display("FAIL drop_same_cycle got=%h exp=%h", got_v(), exp_v(1, 3, 32'h11, 0, 1));
    end
    tick(); idle(); sample();
    total++;
    if (got_v() !== exp_v(0, 0, 0, 0, 1)) begin
      bad++; $display("FAIL drop_no_pend got=%h exp=%h", got_v(), exp_v(0, 0, 0, 0, 1));
    end
    tick();
  endtask

  task automatic test_r0();
    set_wb(0, 32'hFFFF); set_ld(5, 32'h66);
    sample();
    total++;
    if (got_v() !== exp_v(1, 5, 32'h66, 0, 1)) begin
      bad++; $display("FAIL r0_wb_ld5 got=%h exp=%h", got_v(), exp_v(1, 5, 32'h66, 0, 1));
    end
    tick(); idle();
    set_ld(0, 32'h99);
    sample();
    total++;
    if (got_v() !== exp_v(0, 0, 0, 0, 1)) begin
      bad++; $display("FAIL r0_ld_only got=%h exp=%h", got_v(), exp_v(0, 0, 0, 0, 1));
    end
    tick(); idle(); sample();
    total++;
    if (got_v() !== exp_v(0, 0, 0, 0, 1)) begin
      bad++; $display("FAIL r0_after got=%h exp=%h", got_v(), exp_v(0, 0, 0, 0, 1));
    end
    tick();
  endtask

  task automatic test_mid_reset();
    if (SWEEP) begin
      idle(); rst_n = 0; sample(); tick(); rst_n = 1;
      for (int i = 0; i < 10; i++) begin sample(); tick(); end
    end else begin
      make_pend();
    end
    rst_n = 0;
    sample();
    total++;
    if (got_v() !== exp_v(0, 0, 0, 1, 0)) begin
      bad++; $display("FAIL midrst_hold got=%h exp=%h", got_v(), exp_v(0, 0, 0, 1, 0));
    end
    tick();
    rst_n = 1;
    clear_model();
    sample();
    total++;
    if (SWEEP) begin
      if (got_v() !== exp_v(1, 0, 0, 1, 0)) begin
        bad++; $display("FAIL midrst_restart got=%h exp=%h", got_v(), exp_v(1, 0, 0, 1, 0));
      end
      tick();
      for (int i = 1; i < DEPTH; i++) begin sample(); tick(); end
      sample();
      total++;
    end
    if (got_v() !== exp_v(0, 0, 0, 0, 1)) begin
      bad++; $display("FAIL midrst_pend_gone got=%h exp=%h", got_v(), exp_v(0, 0, 0, 0, 1));
    end
    tick();
  endtask

  task automatic test_random();
    int ld_wait = 0;
    idle();
    for (int c = 0; c < 600; c++) begin
      if (!wb_valid && ($urandom_range(0, 2) != 0)) set_wb(AW'($urandom_range(0, 7)), $urandom);
      if (!ld_valid && ($urandom_range(0, 1) != 0)) set_ld(AW'($urandom_range(0, 7)), $urandom);
      sample();
      total++;
      if (s_stall && (!wb_valid || wb_addr == 0)) begin
        bad++; $display("FAIL rnd_spurious_stall cyc=%0d got=1 exp=0", c);
      end
      total++;
      if (s_wren && s_addr == 0) begin
        bad++; $display("FAIL rnd_r0_write cyc=%0d got=addr0 exp=none", c);
      end
      if (ld_valid && !s_ready) ld_wait++; else ld_wait = 0;
      total++;
      if (ld_wait > 1) begin
        bad++; $display("FAIL rnd_ld_wait cyc=%0d got=%0d exp<=1", c, ld_wait);
      end
      begin
        logic wb_acc, ld_acc;
        wb_acc = wb_valid && !s_stall;
        ld_acc = ld_valid && s_ready;
        tick();
        if (wb_acc) wb_valid = 0;
        if (ld_acc) ld_valid = 0;
      end
    end
    idle();
    for (int i = 0; i < 3; i++) begin sample(); tick(); end
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (obs[i] !== arch[i]) begin
        bad++; $display("FAIL rnd_rf_r%0d got=%h exp=%h", i, obs[i], arch[i]);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_wb_and_load();
    test_stall();
    test_cancel();
    test_same_addr_drop();
    test_r0();
    test_mid_reset();
    do_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
